mc_control_fsm: RTL and testbench

Multi-cycle control state machine for the RV32I-subset core; sits directly upstream of the ALU and drives its `alu_op` and operand selects together with all datapath write enables. Decodes the latched instruction register fields, steps each instruction through fetch/decode/execute/memory/write-back cycles, and uses the ALU's `alu_bcond` to resolve branches. Memory accesses stall on a ready handshake.

---
 rtl/mc_control_fsm_if.sv | 36 +++
 rtl/mc_control_fsm.sv | 235 +++++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multi-cycle FSM (master) and the datapath (slave).
interface mc_control_fsm_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       alu_bcond;
  logic       mem_ready;
  logic [3:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       alu_out_write;
  logic       pc_write;
  logic       pc_source;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] wb_sel;
  logic       is_halted;
  logic       illegal_instr;

  modport master (
    input  opcode, funct3, funct7_5, alu_bcond, mem_ready,
    output alu_op, alu_src_a, alu_src_b, alu_out_write, pc_write, pc_source,
           i_or_d, mem_read, mem_write, ir_write, reg_write, wb_sel,
           is_halted, illegal_instr
  );

  modport slave (
    output opcode, funct3, funct7_5, alu_bcond, mem_ready,
    input  alu_op, alu_src_a, alu_src_b, alu_out_write, pc_write, pc_source,
           i_or_d, mem_read, mem_write, ir_write, reg_write, wb_sel,
           is_halted, illegal_instr
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control FSM: one state per cycle, registered controls, IF/MEM stall while mem_ready=0.
// Define MC_CTRL_ILLEGAL_TRAP_EN to halt on illegal instructions; otherwise they retire as NOPs.
module mc_control_fsm (
  input  logic             clk,
  input  logic             reset,
  mc_control_fsm_if.master bus
);
  typedef enum logic [2:0] {
    S_IF, S_ID, S_EX, S_MEM, S_WB, S_PC4, S_JR, S_HALT
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1010;
  localparam logic [3:0] ALU_SRL = 4'b1011;

  localparam logic [3:0] BR_EQ = 4'b0000;
  localparam logic [3:0] BR_NE = 4'b1010;
  localparam logic [3:0] BR_LT = 4'b1000;
  localparam logic [3:0] BR_GE = 4'b1011;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  localparam state_t ILLEGAL_NEXT = S_HALT;
`else
  localparam state_t ILLEGAL_NEXT = S_PC4;
`endif

  // br_en marks the branch EX cycle; pc_write/pc_source there follow alu_bcond live.
  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_out_write;
    logic       pc_write;
    logic       pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       br_en;
  } ctrl_t;

  localparam ctrl_t CTRL_IF = '{mem_read: 1'b1, ir_write: 1'b1, default: '0};

  state_t     state;
  state_t     state_nxt;
  ctrl_t      ctrl_q;
  ctrl_t      ctrl_nxt;
  logic       halted_q;
  logic [3:0] arith_op;
  logic       arith_ok;
  logic [3:0] br_op;
  logic       br_ok;
  logic       legal;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic       illegal_q;
`endif

  always_comb begin
    arith_op = ALU_ADD;
    arith_ok = 1'b1;
    case (bus.funct3)
      3'b000:  arith_op = (bus.opcode == OP_R && bus.funct7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  begin arith_op = ALU_SLL; arith_ok = !bus.funct7_5; end
      3'b100:  arith_op = ALU_XOR;
      3'b101:  begin arith_op = ALU_SRL; arith_ok = !bus.funct7_5; end
      3'b110:  arith_op = ALU_OR;
      3'b111:  arith_op = ALU_AND;
      default: arith_ok = 1'b0;
    endcase

    br_op = BR_EQ;
    br_ok = 1'b1;
    case (bus.funct3)
      3'b000:  br_op = BR_EQ;
      3'b001:  br_op = BR_NE;
      3'b100:  br_op = BR_LT;
      3'b101:  br_op = BR_GE;
      default: br_ok = 1'b0;
    endcase

    // In I-type funct7_5 is an immediate bit, so only R-type rejects it outside SUB.
    legal = 1'b0;
    case (bus.opcode)
      OP_R:              legal = arith_ok && (!bus.funct7_5 || bus.funct3 == 3'b000);
      OP_I:              legal = arith_ok;
      OP_LOAD, OP_STORE: legal = (bus.funct3 == 3'b010);
      OP_BRANCH:         legal = br_ok;
      OP_JAL, OP_SYSTEM: legal = 1'b1;
      OP_JALR:           legal = (bus.funct3 == 3'b000);
      default:           legal = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IF:  if (bus.mem_ready) state_nxt = S_ID;
      S_ID: begin
        if (bus.opcode == OP_SYSTEM) state_nxt = S_HALT;
        else if (!legal)             state_nxt = ILLEGAL_NEXT;
        else                         state_nxt = S_EX;
      end
      S_EX: begin
        case (bus.opcode)
          OP_R, OP_I:        state_nxt = S_WB;
          OP_LOAD, OP_STORE: state_nxt = S_MEM;
          OP_BRANCH:         state_nxt = bus.alu_bcond ? S_IF : S_PC4;
          OP_JAL:            state_nxt = S_IF;
          OP_JALR:           state_nxt = S_JR;
          default:           state_nxt = S_PC4;
        endcase
      end
      S_MEM: if (bus.mem_ready) state_nxt = (bus.opcode == OP_LOAD) ? S_WB : S_PC4;
      S_WB:   state_nxt = S_PC4;
      S_PC4:  state_nxt = S_IF;
      S_JR:   state_nxt = S_IF;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IF;
    endcase
  end

  // Controls for the state being entered, so they are registered yet valid on arrival.
  always_comb begin
    ctrl_nxt = '0;
    case (state_nxt)
      S_IF: ctrl_nxt = CTRL_IF;
      S_ID: begin
        ctrl_nxt.alu_src_b     = 2'd2;
        ctrl_nxt.alu_out_write = 1'b1;
      end
      S_EX: begin
        case (bus.opcode)
          OP_R, OP_I: begin
            ctrl_nxt.alu_op        = arith_op;
            ctrl_nxt.alu_src_a     = 1'b1;
            ctrl_nxt.alu_src_b     = (bus.opcode == OP_I) ? 2'd2 : 2'd0;
            ctrl_nxt.alu_out_write = 1'b1;
          end
          OP_LOAD, OP_STORE, OP_JALR: begin
            ctrl_nxt.alu_src_a     = 1'b1;
            ctrl_nxt.alu_src_b     = 2'd2;
            ctrl_nxt.alu_out_write = 1'b1;
          end
          OP_BRANCH: begin
            ctrl_nxt.alu_op    = br_op;
            ctrl_nxt.alu_src_a = 1'b1;
            ctrl_nxt.br_en     = 1'b1;
          end
          OP_JAL: begin
            ctrl_nxt.alu_src_b = 2'd1;
            ctrl_nxt.reg_write = 1'b1;
            ctrl_nxt.wb_sel    = 2'd2;
            ctrl_nxt.pc_write  = 1'b1;
            ctrl_nxt.pc_source = 1'b1;
          end
          default: ctrl_nxt = '0;
        endcase
      end
      S_MEM: begin
        ctrl_nxt.i_or_d    = 1'b1;
        ctrl_nxt.mem_read  = (bus.opcode == OP_LOAD);
        ctrl_nxt.mem_write = (bus.opcode == OP_STORE);
      end
      S_WB: begin
        ctrl_nxt.reg_write = 1'b1;
        ctrl_nxt.wb_sel    = (bus.opcode == OP_LOAD) ? 2'd1 : 2'd0;
      end
      S_PC4: begin
        ctrl_nxt.alu_src_b = 2'd1;
        ctrl_nxt.pc_write  = 1'b1;
      end
      S_JR: begin
        ctrl_nxt.alu_src_b = 2'd1;
        ctrl_nxt.reg_write = 1'b1;
        ctrl_nxt.wb_sel    = 2'd2;
        ctrl_nxt.pc_write  = 1'b1;
        ctrl_nxt.pc_source = 1'b1;
      end
      default: ctrl_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IF;
      ctrl_q   <= CTRL_IF;
      halted_q <= 1'b0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      ctrl_q   <= ctrl_nxt;
      halted_q <= (state_nxt == S_HALT);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      illegal_q <= illegal_q | (state == S_ID && !legal);
`endif
    end
  end

  // Write enables are masked during reset so an aborted instruction never commits.
  assign bus.alu_op        = ctrl_q.alu_op;
  assign bus.alu_src_a     = ctrl_q.alu_src_a;
  assign bus.alu_src_b     = ctrl_q.alu_src_b;
  assign bus.alu_out_write = ctrl_q.alu_out_write & ~reset;
  assign bus.pc_write      = (ctrl_q.pc_write | (ctrl_q.br_en & bus.alu_bcond)) & ~reset;
  assign bus.pc_source     = ctrl_q.pc_source | (ctrl_q.br_en & bus.alu_bcond);
  assign bus.i_or_d        = ctrl_q.i_or_d;
  assign bus.mem_read      = ctrl_q.mem_read;
  assign bus.mem_write     = ctrl_q.mem_write & ~reset;
  assign bus.ir_write      = ctrl_q.ir_write & ~reset;
  assign bus.reg_write     = ctrl_q.reg_write & ~reset;
  assign bus.wb_sel        = ctrl_q.wb_sel;
  assign bus.is_halted     = halted_q;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign bus.illegal_instr = illegal_q;
`else
  assign bus.illegal_instr = 1'b0;
`endif
endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: per-instruction expected cycle traces built from the control rules, random stalls/branches.
module tb_mc_control_fsm;
  logic clk = 1'b0;
  logic reset;

  mc_control_fsm_if bus ();
  mc_control_fsm dut (.clk(clk), .reset(reset), .bus(bus.master));

  always #5 clk = ~clk;

  localparam logic [3:0] K_R = 4'd0, K_I = 4'd1, K_LW = 4'd2, K_SW = 4'd3, K_BR = 4'd4;
  localparam logic [3:0] K_JAL = 4'd5, K_JALR = 4'd6, K_ECALL = 4'd7, K_ILL = 4'd8;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct packed {
    logic [6:0] opc;
    logic [2:0] f3;
    logic       f7;
    logic [3:0] kind;
    logic [3:0] op;
  } instr_t;

  instr_t      legal_tab[$];
  instr_t      bad_tab[$];
  logic [18:0] exp_q[$];
  string       ph_q[$];
  int          rdy_q[$];
  int          bc_q[$];
  int          checks = 0;
  int          errors = 0;

  function automatic instr_t mk(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                input logic [3:0] kind, input logic [3:0] op);
    instr_t r;
    r.opc = opc; r.f3 = f3; r.f7 = f7; r.kind = kind; r.op = op;
    return r;
  endfunction

  // {alu_op, src_a, src_b, alu_out_write, pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_write, wb_sel, is_halted, illegal_instr}
  function automatic logic [18:0] vec(input logic [3:0] op, input logic sa, input logic [1:0] sb,
                                      input logic aow, input logic pcw, input logic pcs, input logic iod,
                                      input logic mr, input logic mw, input logic irw, input logic rw,
                                      input logic [1:0] wb, input logic h, input logic ill);
    return {op, sa, sb, aow, pcw, pcs, iod, mr, mw, irw, rw, wb, h, ill};
  endfunction

  function automatic logic [18:0] obs();
    return {bus.alu_op, bus.alu_src_a, bus.alu_src_b, bus.alu_out_write, bus.pc_write,
            bus.pc_source, bus.i_or_d, bus.mem_read, bus.mem_write, bus.ir_write,
            bus.reg_write, bus.wb_sel, bus.is_halted, bus.illegal_instr};
  endfunction

  task automatic push(input string n, input logic [18:0] v, input int r, input int b);
    ph_q.push_back(n); exp_q.push_back(v); rdy_q.push_back(r); bc_q.push_back(b);
  endtask

  // rdy/bc value 2 means "drive randomly": the DUT must not depend on it in that cycle.
  task automatic build(input instr_t ins, input int stall_if, input int stall_mem, input bit taken);
    logic [18:0] v_if, v_pc4, v_link, v_addr;
    v_if   = vec(4'd0, 0, 2'd0, 0, 0, 0, 0, 1, 0, 1, 0, 2'd0, 0, 0);
    v_pc4  = vec(4'd0, 0, 2'd1, 0, 1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0);
    v_link = vec(4'd0, 0, 2'd1, 0, 1, 1, 0, 0, 0, 0, 1, 2'd2, 0, 0);
    v_addr = vec(4'd0, 1, 2'd2, 1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0);
    repeat (stall_if) push("IF", v_if, 0, 2);
    push("IF", v_if, 1, 2);
    push("ID", vec(4'd0, 0, 2'd2, 1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0), 2, 2);
    case (ins.kind)
      K_R, K_I: begin
        push("EX", vec(ins.op, 1, (ins.kind == K_I) ? 2'd2 : 2'd0, 1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0), 2, 2);
        push("WB", vec(4'd0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 0, 0), 2, 2);
        push("PC4", v_pc4, 2, 2);
      end
      K_LW, K_SW: begin
        logic [18:0] v_mem;
        v_mem = (ins.kind == K_LW) ? vec(4'd0, 0, 2'd0, 0, 0, 0, 1, 1, 0, 0, 0, 2'd0, 0, 0)
                                   : vec(4'd0, 0, 2'd0, 0, 0, 0, 1, 0, 1, 0, 0, 2'd0, 0, 0);
        push("EX", v_addr, 2, 2);
        repeat (stall_mem) push("MEM", v_mem, 0, 2);
        push("MEM", v_mem, 1, 2);
        if (ins.kind == K_LW)
          push("WB", vec(4'd0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd1, 0, 0), 2, 2);
        push("PC4", v_pc4, 2, 2);
      end
      K_BR: begin
        push("EX", vec(ins.op, 1, 2'd0, 0, taken, taken, 0, 0, 0, 0, 0, 2'd0, 0, 0), 2, int'(taken));
        if (!taken) push("PC4", v_pc4, 2, 2);
      end
      K_JAL:  push("EX", v_link, 2, 2);
      K_JALR: begin
        push("EX", v_addr, 2, 2);
        push("JR", v_link, 2, 2);
      end
      K_ECALL: repeat (4) push("HALT", vec(4'd0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1, 0), 2, 2);
      default: begin
        if (TRAP) repeat (4) push("HALT", vec(4'd0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1, 1), 2, 2);
        else      push("PC4", v_pc4, 2, 2);
      end
    endcase
  endtask

  task automatic set_ir(input instr_t ins);
    bus.opcode = ins.opc; bus.funct3 = ins.f3; bus.funct7_5 = ins.f7;
  endtask

  task automatic run_trace(input string tag, input int limit);
    int n;
    n = exp_q.size();
    if (limit < n) n = limit;
    for (int i = 0; i < n; i++) begin
      bus.mem_ready = (rdy_q[i] == 2) ? 1'($urandom_range(0, 1)) : (rdy_q[i] == 1);
      bus.alu_bcond = (bc_q[i] == 2)  ? 1'($urandom_range(0, 1)) : (bc_q[i] == 1);
      @(negedge clk);
      checks++;
      if (obs() !== exp_q[i]) begin
        errors++;
        $display("FAIL %s cycle %0d (%s): got %b want %b", tag, i, ph_q[i], obs(), exp_q[i]);
      end
      @(posedge clk); #1;
    end
    exp_q.delete(); ph_q.delete(); rdy_q.delete(); bc_q.delete();
  endtask

  task automatic do_instr(input string tag, input instr_t ins, input int si, input int sm, input bit t);
    set_ir(ins);
    build(ins, si, sm, t);
    run_trace(tag, 1000);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; bus.mem_ready = 1'b1; bus.alu_bcond = 1'b1;
    repeat (n) begin
      @(negedge clk);
      checks++;
      if ({bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write, bus.alu_out_write} !== 5'b0) begin
        errors++;
        $display("FAIL reset_enables: got %b want 00000",
                 {bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write, bus.alu_out_write});
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.opcode = 7'b0110011; bus.funct3 = 3'b000; bus.funct7_5 = 1'b0;
    do_reset(3);
    for (int i = 0; i < 2; i++) begin
      bus.mem_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (obs() !== vec(4'd0, 0, 2'd0, 0, 0, 0, 0, 1, 0, 1, 0, 2'd0, 0, 0)) begin
        errors++;
        $display("FAIL reset_state_if: got %b", obs());
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_add();
    do_instr("add", mk(7'b0110011, 3'b000, 1'b0, K_R, 4'b0000), 0, 0, 1'b0);
    do_instr("sub", mk(7'b0110011, 3'b000, 1'b1, K_R, 4'b0001), 1, 0, 1'b0);
  endtask

  task automatic test_lw_stall();
    do_instr("lw_stall", mk(7'b0000011, 3'b010, 1'b0, K_LW, 4'b0000), 0, 2, 1'b0);
    do_instr("sw_stall", mk(7'b0100011, 3'b010, 1'b0, K_SW, 4'b0000), 2, 1, 1'b0);
  endtask

  task automatic test_branch();
    do_instr("bne_taken", mk(7'b1100011, 3'b001, 1'b0, K_BR, 4'b1010), 0, 0, 1'b1);
    do_instr("bne_not",   mk(7'b1100011, 3'b001, 1'b0, K_BR, 4'b1010), 0, 0, 1'b0);
    do_instr("bge_taken", mk(7'b1100011, 3'b101, 1'b0, K_BR, 4'b1011), 0, 0, 1'b1);
  endtask

  task automatic test_jump();
    do_instr("jalr", mk(7'b1100111, 3'b000, 1'b0, K_JALR, 4'b0000), 0, 0, 1'b0);
    do_instr("jal",  mk(7'b1101111, 3'b011, 1'b1, K_JAL, 4'b0000), 0, 0, 1'b0);
  endtask

  task automatic test_ecall();
    do_instr("ecall", mk(7'b1110011, 3'b000, 1'b0, K_ECALL, 4'b0000), 0, 0, 1'b0);
    do_reset(2);
    do_instr("after_ecall", mk(7'b0010011, 3'b111, 1'b0, K_I, 4'b0100), 0, 0, 1'b0);
  endtask

  task automatic test_illegal();
    foreach (bad_tab[i]) begin
      do_instr("illegal", bad_tab[i], 0, 0, 1'b0);
      if (TRAP) do_reset(1);
    end
  endtask

  task automatic test_reset_mid();
    instr_t sw;
    instr_t jal;
    sw  = mk(7'b0100011, 3'b010, 1'b0, K_SW, 4'b0000);
    jal = mk(7'b1101111, 3'b000, 1'b0, K_JAL, 4'b0000);
    set_ir(sw);  build(sw, 0, 3, 1'b0);  run_trace("sw_abort", 5);
    do_reset(1);
    set_ir(jal); build(jal, 0, 0, 1'b0); run_trace("jal_abort", 2);
    do_reset(1);
    do_instr("after_abort", mk(7'b0110011, 3'b110, 1'b0, K_R, 4'b0101), 0, 0, 1'b0);
  endtask

  task automatic test_random();
    instr_t ins;
    for (int n = 0; n < 300; n++) begin
      ins = legal_tab[$urandom_range(0, legal_tab.size() - 1)];
      do_instr("random", ins, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.mem_ready = 1'b1; bus.alu_bcond = 1'b0;
    bus.opcode = 7'd0; bus.funct3 = 3'd0; bus.funct7_5 = 1'b0;

    legal_tab.push_back(mk(7'b0110011, 3'b000, 1'b0, K_R, 4'b0000));
    legal_tab.push_back(mk(7'b0110011, 3'b000, 1'b1, K_R, 4'b0001));
    legal_tab.push_back(mk(7'b0110011, 3'b111, 1'b0, K_R, 4'b0100));
    legal_tab.push_back(mk(7'b0110011, 3'b110, 1'b0, K_R, 4'b0101));
    legal_tab.push_back(mk(7'b0110011, 3'b100, 1'b0, K_R, 4'b1000));
    legal_tab.push_back(mk(7'b0110011, 3'b001, 1'b0, K_R, 4'b1010));
    legal_tab.push_back(mk(7'b0110011, 3'b101, 1'b0, K_R, 4'b1011));
    legal_tab.push_back(mk(7'b0010011, 3'b000, 1'b1, K_I, 4'b0000));
    legal_tab.push_back(mk(7'b0010011, 3'b111, 1'b1, K_I, 4'b0100));
    legal_tab.push_back(mk(7'b0010011, 3'b110, 1'b0, K_I, 4'b0101));
    legal_tab.push_back(mk(7'b0010011, 3'b100, 1'b1, K_I, 4'b1000));
    legal_tab.push_back(mk(7'b0010011, 3'b001, 1'b0, K_I, 4'b1010));
    legal_tab.push_back(mk(7'b0010011, 3'b101, 1'b0, K_I, 4'b1011));
    legal_tab.push_back(mk(7'b0000011, 3'b010, 1'b0, K_LW, 4'b0000));
    legal_tab.push_back(mk(7'b0100011, 3'b010, 1'b1, K_SW, 4'b0000));
    legal_tab.push_back(mk(7'b1100011, 3'b000, 1'b0, K_BR, 4'b0000));
    legal_tab.push_back(mk(7'b1100011, 3'b001, 1'b0, K_BR, 4'b1010));
    legal_tab.push_back(mk(7'b1100011, 3'b100, 1'b0, K_BR, 4'b1000));
    legal_tab.push_back(mk(7'b1100011, 3'b101, 1'b1, K_BR, 4'b1011));
    legal_tab.push_back(mk(7'b1101111, 3'b010, 1'b0, K_JAL, 4'b0000));
    legal_tab.push_back(mk(7'b1100111, 3'b000, 1'b1, K_JALR, 4'b0000));

    bad_tab.push_back(mk(7'b0110011, 3'b010, 1'b0, K_ILL, 4'b0000));
    bad_tab.push_back(mk(7'b0110011, 3'b101, 1'b1, K_ILL, 4'b0000));
    bad_tab.push_back(mk(7'b0110011, 3'b100, 1'b1, K_ILL, 4'b0000));
    bad_tab.push_back(mk(7'b0010011, 3'b101, 1'b1, K_ILL, 4'b0000));
    bad_tab.push_back(mk(7'b0010011, 3'b011, 1'b0, K_ILL, 4'b0000));
    bad_tab.push_back(mk(7'b0000011, 3'b000, 1'b0, K_ILL, 4'b0000));
    bad_tab.push_back(mk(7'b0100011, 3'b001, 1'b0, K_ILL, 4'b0000));
    bad_tab.push_back(mk(7'b1100011, 3'b010, 1'b0, K_ILL, 4'b0000));
    bad_tab.push_back(mk(7'b1100111, 3'b001, 1'b0, K_ILL, 4'b0000));
    bad_tab.push_back(mk(7'b0110111, 3'b000, 1'b0, K_ILL, 4'b0000));

    test_reset();
    test_add();
    test_lw_stall();
    test_branch();
    test_jump();
    test_ecall();
    test_illegal();
    test_reset_mid();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
